// File: rtl/clb_cfg_pkg.sv
// Shared definitions for the CLB configuration loader, its testbenches and bitstream tools.
package clb_cfg_pkg;

  localparam int unsigned CFG_SIZE_DEF = 256;
  localparam int unsigned WORD_W_DEF   = 8;

  // Bit offsets of the CLB configuration fields within cfg
  localparam int unsigned LUT_OFS  = 0;
  localparam int unsigned DFF_OFS  = 132;
  localparam int unsigned OMUX_OFS = 140;
  localparam int unsigned CC_OFS   = 148;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  function automatic int unsigned nwords(input int unsigned cfg_size, input int unsigned word_w);
    return (cfg_size + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/clb_cfg_loader.sv
// Word-serial CLB configuration loader: shadow assembly, XOR checksum, atomic commit to cfg.
module clb_cfg_loader
  import clb_cfg_pkg::*;
#(
  parameter int unsigned CFG_SIZE = CFG_SIZE_DEF,
  parameter int unsigned WORD_W   = WORD_W_DEF
) (
  input  logic                clk,
  input  logic                crst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [WORD_W-1:0]   in_data,
  output logic                in_ready,
  output logic [CFG_SIZE-1:0] cfg,
  output logic                cfg_valid,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned NWORDS = nwords(CFG_SIZE, WORD_W);
  localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(NWORDS - 1);
  localparam logic [CFG_SIZE-1:0] WORD_MASK = CFG_SIZE'({WORD_W{1'b1}});

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   acc;
  logic [CFG_SIZE-1:0] shadow;
  logic [CFG_SIZE-1:0] shadow_wr;
  logic [31:0]         bit_ofs;
  logic                commit_pend;
  logic                err_pend;
  logic                hs;

  assign in_ready = (state == ST_LOAD) || (state == ST_CHECK);
  assign busy     = in_ready;
  assign hs       = in_valid & in_ready;

  // Shifting past CFG_SIZE drops the ragged-tail bits of the last word
  always_comb begin
    bit_ofs   = WORD_W * 32'(cnt);
    shadow_wr = (shadow & ~(WORD_MASK << bit_ofs)) | (CFG_SIZE'(in_data) << bit_ofs);
  end

  always_ff @(posedge clk or posedge crst) begin
    if (crst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      acc         <= '0;
      shadow      <= '0;
      cfg         <= '0;
      cfg_valid   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      commit_pend <= 1'b0;
      err_pend    <= 1'b0;
    end else begin
      done        <= 1'b0;
      commit_pend <= 1'b0;
      err_pend    <= 1'b0;

      // The checksum verdict lands one edge after the checksum handshake
      if (commit_pend) begin
        cfg       <= shadow;
        cfg_valid <= 1'b1;
        done      <= 1'b1;
      end

      if (start) begin
        state <= ST_LOAD;
        cnt   <= '0;
        acc   <= '0;
        err   <= 1'b0;
      end else begin
        if (err_pend) begin
          err <= 1'b1;
        end
        case (state)
          ST_LOAD: begin
            if (hs) begin
              shadow <= shadow_wr;
              acc    <= acc ^ in_data;
              cnt    <= cnt + 1'b1;
              if (cnt == LAST_CNT) begin
                state <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            if (hs) begin
              if (in_data == acc) begin
                commit_pend <= 1'b1;
              end else begin
                err_pend <= 1'b1;
              end
              state <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Self-checking bench for clb_cfg_loader: table-driven loads, random loads, abort/reset/ragged-tail cases.
module tb_clb_cfg_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         start0 = 1'b0, valid0 = 1'b0;
  logic [7:0]   data0 = '0;
  logic         ready0, cfgv0, busy0, done0, err0;
  logic [255:0] cfg0;

  logic         start1 = 1'b0, valid1 = 1'b0;
  logic [7:0]   data1 = '0;
  logic         ready1, cfgv1, busy1, done1, err1;
  logic [19:0]  cfg1;

  int checks = 0;
  int failures = 0;

  logic [7:0]   words [0:31];
  logic [255:0] exp_cfg = '0;
  logic         exp_valid = 1'b0;
  logic         exp_err = 1'b0;
  logic [19:0]  exp_cfg1 = '0;
  logic         exp_valid1 = 1'b0;

  typedef struct {
    bit [1:0] pat;
    bit       bad_cs;
    bit       rnd;
    bit       exp_done;
    bit       exp_err;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  clb_cfg_loader #(.CFG_SIZE(256), .WORD_W(8)) dut0 (
    .clk(clk), .crst(rst), .start(start0), .in_valid(valid0), .in_data(data0),
    .in_ready(ready0), .cfg(cfg0), .cfg_valid(cfgv0), .busy(busy0), .done(done0), .err(err0)
  );

  clb_cfg_loader #(.CFG_SIZE(20), .WORD_W(8)) dut1 (
    .clk(clk), .crst(rst), .start(start1), .in_valid(valid1), .in_data(data1),
    .in_ready(ready1), .cfg(cfg1), .cfg_valid(cfgv1), .busy(busy1), .done(done1), .err(err1)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: bit k of the configuration is bit k%8 of word k/8
  function automatic logic [255:0] model_cfg();
    logic [255:0] r;
    for (int k = 0; k < 256; k++) r[k] = words[k / 8][k % 8];
    return r;
  endfunction

  function automatic logic [7:0] model_xsum();
    logic [7:0] x = '0;
    for (int i = 0; i < 32; i++) x = x ^ words[i];
    return x;
  endfunction

  task automatic fill_words(input bit [1:0] pat);
    for (int i = 0; i < 32; i++) begin
      case (pat)
        2'd0: words[i] = 8'(i);
        2'd1: words[i] = 8'hA5;
        2'd2: words[i] = 8'((i * 37 + 11) % 256);
        default: words[i] = 8'($urandom);
      endcase
    end
  endtask

  task automatic run_load0(input logic [7:0] corrupt, input bit rnd, input bit pre_valid,
                           input bit exp_done, input bit exp_e);
    logic [7:0] cs;
    bit hold_ok;
    int n;
    cs = model_xsum() ^ corrupt;
    start0 = 1'b1;
    if (pre_valid) begin
      valid0 = 1'b1;
      data0  = 8'($urandom);
    end
    @(posedge clk); #1;
    start0 = 1'b0;
    valid0 = 1'b0;
    n = 0;
    exp_err = 1'b0;
    check("busy_after_start", 256'(busy0), 256'(1'b1));
    check("ready_after_start", 256'(ready0), 256'(1'b1));
    hold_ok = 1'b1;
    for (int w = 0; w <= 32; w++) begin
      bit got;
      int tries;
      got = 1'b0;
      tries = 0;
      while (!got) begin
        valid0 = (rnd && tries < 8) ? ($urandom_range(0, 1) == 1) : 1'b1;
        data0  = (w < 32) ? words[w] : cs;
        got    = valid0;
        @(posedge clk); #1;
        n++;
        tries++;
        if (cfg0 !== exp_cfg || cfgv0 !== exp_valid || done0 !== 1'b0 || err0 !== 1'b0)
          hold_ok = 1'b0;
      end
    end
    valid0 = 1'b0;
    check("cfg_held_during_load", 256'(hold_ok), 256'(1'b1));
    check("idle_after_check", 256'({ready0, busy0}), 256'(2'b00));
    @(posedge clk); #1;
    n++;
    if (exp_done) begin
      exp_cfg   = model_cfg();
      exp_valid = 1'b1;
    end
    exp_err = exp_e;
    if (!rnd && exp_done) check("done_at_cycle", 256'(done0 ? n : -1), 256'(34));
    check("done_pulse", 256'(done0), 256'(exp_done));
    check("cfg_after_commit", cfg0, exp_cfg);
    check("cfg_valid", 256'(cfgv0), 256'(exp_valid));
    check("err_flag", 256'(err0), 256'(exp_err));
    @(posedge clk); #1;
    check("done_one_cycle", 256'(done0), 256'(1'b0));
    check("err_sticky", 256'(err0), 256'(exp_err));
  endtask

  task automatic run_load1(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input logic [7:0] cs, input bit exp_ok);
    logic [7:0]  stream [4];
    logic [23:0] full;
    stream[0] = w0; stream[1] = w1; stream[2] = w2; stream[3] = cs;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid1 = 1'b1;
      data1  = stream[i];
      @(posedge clk); #1;
    end
    valid1 = 1'b0;
    check("r_no_early_done", 256'(done1), 256'(1'b0));
    @(posedge clk); #1;
    if (exp_ok) begin
      full = {w2, w1, w0};
      exp_cfg1   = full[19:0];
      exp_valid1 = 1'b1;
    end
    check("r_done", 256'(done1), 256'(exp_ok));
    check("r_err", 256'(err1), 256'(!exp_ok));
    check("r_cfg", 256'(cfg1), 256'(exp_cfg1));
    check("r_cfg_valid", 256'(cfgv1), 256'(exp_valid1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{pat: 2'd0, bad_cs: 1'b1, rnd: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[1] = '{pat: 2'd0, bad_cs: 1'b0, rnd: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{pat: 2'd1, bad_cs: 1'b0, rnd: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{pat: 2'd2, bad_cs: 1'b0, rnd: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{pat: 2'd3, bad_cs: 1'b1, rnd: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
    vecs[5] = '{pat: 2'd3, bad_cs: 1'b0, rnd: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[6] = '{pat: 2'd3, bad_cs: 1'b0, rnd: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[7] = '{pat: 2'd1, bad_cs: 1'b1, rnd: 1'b1, exp_done: 1'b0, exp_err: 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("reset_cfg", cfg0, 256'(0));
    check("reset_flags", 256'({cfgv0, ready0, busy0, done0, err0}), 256'(5'b0));
    check("reset_flags_r", 256'({cfgv1, ready1, busy1, done1, err1, cfg1}), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      fill_words(vecs[v].pat);
      run_load0(vecs[v].bad_cs ? 8'hFF : 8'h00, vecs[v].rnd, 1'b0, vecs[v].exp_done, vecs[v].exp_err);
      if (v == 1) begin
        check("ramp_low_byte", 256'(cfg0[7:0]), 256'(8'h00));
        check("ramp_high_byte", 256'(cfg0[255:248]), 256'(8'h1F));
      end
    end

    for (int r = 0; r < 6; r++) begin
      bit bad;
      bad = ($urandom_range(0, 3) == 0);
      fill_words(2'd3);
      run_load0(bad ? 8'($urandom_range(1, 255)) : 8'h00, ($urandom_range(0, 1) == 1), 1'b0, !bad, bad);
    end

    // Abort after 10 words; restart edge carries a word that must be ignored
    fill_words(2'd3);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid0 = 1'b1;
      data0  = 8'($urandom);
      @(posedge clk); #1;
    end
    valid0 = 1'b0;
    fill_words(2'd2);
    run_load0(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset while in CHECK with a valid checksum presented
    fill_words(2'd3);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      valid0 = 1'b1;
      data0  = words[i];
      @(posedge clk); #1;
    end
    data0 = model_xsum();
    #2 rst = 1'b1;
    #1;
    check("crst_async_cfg", cfg0, 256'(0));
    check("crst_async_flags", 256'({cfgv0, ready0, busy0, done0, err0}), 256'(5'b0));
    exp_cfg = '0;
    exp_valid = 1'b0;
    exp_err = 1'b0;
    exp_cfg1 = '0;
    exp_valid1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    valid0 = 1'b0;
    begin
      bit saw_done;
      saw_done = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        if (done0) saw_done = 1'b1;
      end
      check("crst_no_done", 256'(saw_done), 256'(1'b0));
    end
    fill_words(2'd0);
    run_load0(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Ragged tail: 20-bit configuration from three 8-bit words
    run_load1(8'h3C, 8'h81, 8'hB6, 8'h3C ^ 8'h81 ^ 8'h06, 1'b0);
    run_load1(8'h3C, 8'h81, 8'hB6, 8'h3C ^ 8'h81 ^ 8'hB6, 1'b1);
    check("r_tail_nibble", 256'(cfg1[19:16]), 256'(4'h6));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clb_cfg_loader.md
# clb_cfg_loader

Configuration writer for one CLB tile: accepts a word-serial bitstream over a valid/ready handshake, assembles it in a shadow register, verifies an XOR checksum, and atomically commits the result to the `cfg` bus that drives the CLB's LUTs, DFF modes, output muxes and carry-chain init. It sits between the fabric's configuration controller and the CLB's `cfg` input. The CLB never sees a partially loaded or corrupt configuration.

## Interface
- `CFG_SIZE`, 256, width of the committed configuration bus; matches the CLB's `CFG_SIZE`
- `WORD_W`, 8, bitstream word width; NWORDS = ceil(CFG_SIZE/WORD_W) (32 at defaults)

- `clk`  in  1  single clock for the loader and the fabric
- `crst`  in  1  one clock; reset is asynchronous and active-high
- `start`  in  1  one-cycle pulse that begins (or restarts) a load
- `in_valid`  in  1  bitstream word valid
- `in_data`  in  WORD_W  bitstream word
- `in_ready`  out  1  loader accepts a word this cycle
- `cfg`  out  CFG_SIZE  committed configuration, to the CLB
- `cfg_valid`  out  1  `cfg` holds a checksum-verified configuration
- `busy`  out  1  high in LOAD or CHECK
- `done`  out  1  one-cycle pulse on successful commit
- `err`  out  1  sticky checksum-mismatch flag

## Operation
- Reset values: `cfg`=0, `cfg_valid`=0, `in_ready`=0, `busy`=0, `done`=0, `err`=0, state IDLE, word counter 0, checksum accumulator 0.
- A handshake is `in_valid & in_ready` on a rising edge. `in_ready` is a function of state only.
- IDLE: `in_ready`=0. `start` -> LOAD, counter=0, accumulator=0, `err` cleared.
- LOAD: `in_ready`=1. Each handshake writes `in_data` to shadow bits [WORD_W*cnt +: WORD_W]. Word 0 is the LSBs. Each handshake also XORs `in_data` into the accumulator and increments cnt. The handshake at cnt==NWORDS-1 -> CHECK.
- Ragged tail: if CFG_SIZE is not a multiple of WORD_W, the upper bits of the last word are dropped from the shadow but still included in the checksum.
- CHECK: `in_ready`=1. One handshake carries the checksum word. On a match, shadow -> `cfg`, `cfg_valid`=1, `done` pulses. On a mismatch, `err`=1 and `cfg`/`cfg_valid` are unchanged. Both cases -> IDLE.
- `start` in LOAD or CHECK aborts the load and restarts at cnt=0 with the accumulator cleared. The word presented on that same edge is not accepted, because `start` has priority.
- `cfg` and `cfg_valid` keep their old values throughout a reload; only a successful CHECK changes them.
- `cfg_valid` is cleared only by `crst`.
- `crst` mid-load returns everything to the reset values immediately, without waiting for a clock edge.

## Timing
- `start` sampled at edge T -> `busy`=1 and `in_ready`=1 from T+1.
- At full rate, words occupy edges T+1..T+NWORDS and the checksum is at T+NWORDS+1. `cfg`, `cfg_valid` and `done` update at T+NWORDS+2, which is 34 cycles at defaults. Back-to-back `start` is legal on the cycle after `done`.
- A deasserted `in_valid` stalls with no state change; stalls of any length are allowed.
- `cfg` is registered and changes on exactly one edge per commit, with all bits together.
- `err` is set on the checksum edge +1 and stays high until the next `start`.

## Structure
- Shared package `clb_cfg_pkg` holds:
  - the state enum (IDLE, LOAD, CHECK);
  - the default CFG_SIZE/WORD_W;
  - the NWORDS ceil-div function;
  - the CLB field offsets (LUT 0, DFF 132, OMUX 140, CC 148), so testbenches and bitstream tools share one definition.
- Single module; no sub-module is warranted. The shadow register, the counter and the checksum fit comfortably in roughly 150–250 lines.

## Test plan
- Reset -> all outputs 0. `start`, then 32 words 0x00..0x1F and checksum 0x00 at full rate -> `done` pulses 34 cycles after `start`, and `cfg[7:0]`=0x00, `cfg[255:248]`=0x1F, `cfg_valid`=1.
- Same stream with checksum 0xFF -> `err`=1, `cfg` still 0, `cfg_valid`=0, state back to IDLE with `in_ready`=0.
- Valid load of pattern A (all 0xA5, checksum 0x00), then a reload of pattern B with `in_valid` toggled randomly -> `cfg` stays A for the whole reload and switches to B on one edge.
- `start` asserted after word 10 of a load -> the counter restarts. A fresh 33-word stream then commits, and the 10 aborted words have no effect.
- `crst` pulsed mid-CHECK with `in_valid` high -> asynchronous return to reset values with no `done`; a subsequent full load succeeds.
- CFG_SIZE=20, WORD_W=8 (3 words): upper nibble of word 2 is set -> `cfg[19:16]` holds the low nibble only, and the checksum still includes the full byte.
